// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and the future transmitter:
//   - uart_state_e : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - legal ranges for DATA_BITS and OVERSAMPLE
//   - rx_params_ok(): elaboration-time check of a parameter set
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 64;

  // OVERSAMPLE must be a power of two so the bit counter wraps on its own.
  function automatic bit rx_params_ok(input int data_bits, input int oversample,
                                      input int stop_bits, input int parity_odd);
    return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
           (oversample >= OVERSAMPLE_MIN) && (oversample <= OVERSAMPLE_MAX) &&
           ((oversample & (oversample - 1)) == 0) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           ((parity_odd == 0) || (parity_odd == 1));
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Front end of the UART receiver: 2-flop synchroniser on rx, the per-bit
// oversample counter and the 3-sample majority vote around mid-bit.
//   clk, reset  : clock, synchronous active-high reset
//   rx          : asynchronous serial input (idle high)
//   rx_en       : oversample tick, one clk wide
//   idle        : frame FSM is in IDLE (counter parked, hunting a start edge)
//   rx_s        : synchronised rx
//   bit_valid   : 1-cycle pulse when the vote resolves (cnt = OVERSAMPLE/2+1)
//   bit_val     : 2-of-3 majority, valid with bit_valid
//   bit_end     : 1-cycle pulse on the counter wrap (end of a bit period)
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic rx_en,
  input  logic idle,
  output logic rx_s,
  output logic bit_valid,
  output logic bit_val,
  output logic bit_end
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TAP_LO   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TAP_MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] TAP_HI   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          samp_lo_q, samp_lo_d;
  logic          samp_mid_q, samp_mid_d;
  logic          run_tick;
  logic          start_tick;

  assign run_tick   = rx_en & ~idle;
  assign start_tick = rx_en & idle & ~sync2_q;

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    sync1_d    = rx;
    sync2_d    = sync1_q;
    cnt_d      = cnt_q;
    samp_lo_d  = samp_lo_q;
    samp_mid_d = samp_mid_q;

    // The start-detect tick is cnt 0 of the start bit, so the counter
    // leaves IDLE already at 1.
    if (idle) begin
      cnt_d = start_tick ? CW'(1) : '0;
    end else if (rx_en) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (run_tick && (cnt_q == TAP_LO))  samp_lo_d  = sync2_q;
    if (run_tick && (cnt_q == TAP_MID)) samp_mid_d = sync2_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      samp_lo_q  <= 1'b0;
      samp_mid_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      samp_lo_q  <= samp_lo_d;
      samp_mid_q <= samp_mid_d;
    end
  end

  assign rx_s      = sync2_q;
  // The third sample is taken live on the resolving tick.
  assign bit_valid = run_tick & (cnt_q == TAP_HI);
  assign bit_val   = (samp_lo_q & samp_mid_q) | (samp_lo_q & sync2_q) |
                     (samp_mid_q & sync2_q);
  assign bit_end   = run_tick & (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Parametrised UART receiver: start / DATA_BITS data (LSB first) / optional
// parity / STOP_BITS stop bits, with majority voting, false-start rejection,
// framing, parity and overrun flags.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit and check).
//   clk, reset  : clock, synchronous active-high reset
//   rx          : asynchronous serial input, idle high
//   rx_en       : oversample tick (OVERSAMPLE per bit), one clk wide
//   rdy_clr     : clears rdy, overrun, frame_err, parity_err
//   rdy         : a frame is held in data_out
//   data_out    : last received payload
//   frame_err   : a stop bit of the held frame sampled 0
//   parity_err  : parity mismatch on the held frame (0 without the macro)
//   overrun     : a frame completed while rdy was already 1 (sticky)
//   busy        : FSM not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_en,
  input  logic                 rdy_clr,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  if (!rx_params_ok(DATA_BITS, OVERSAMPLE, STOP_BITS, PARITY_ODD)) begin : g_bad_params
    $error("uart_rx_core: unsupported parameter set");
  end

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] INDEX_LAST = IW'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

  uart_state_e          state_q, state_d;
  logic [IW-1:0]        index_q, index_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_acc_q, frame_acc_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 rdy_q, rdy_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 commit;
`ifdef UART_RX_PARITY_EN
  logic                 parity_acc_q, parity_acc_d;
  logic                 parity_err_q, parity_err_d;
`endif

  logic rx_s, bit_valid, bit_val, bit_end;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_en     (rx_en),
    .idle      (state_q == ST_IDLE),
    .rx_s      (rx_s),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    frame_acc_d = frame_acc_q;
    commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_acc_d = parity_acc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rx_en && !rx_s) begin
          state_d     = ST_START;
          frame_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          parity_acc_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        // A start bit that votes high was a glitch: drop back and re-hunt.
        if (bit_valid && bit_val) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
          index_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_valid) shift_d[index_q] = bit_val;
        if (bit_end) begin
          if (index_q == INDEX_LAST) begin
            state_d    = AFTER_DATA;
            stop_idx_d = 1'b0;
          end else begin
            index_d = index_q + IW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_valid) parity_acc_d = bit_val ^ (^shift_q) ^ (PARITY_ODD != 0);
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        // Commit on the last stop-bit vote instead of its end so the next
        // start edge can be caught even with little inter-frame gap.
        if (bit_valid) begin
          if (!bit_val) frame_acc_d = 1'b1;
          if (stop_idx_q == STOP_LAST) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register block; a commit takes priority over rdy_clr in the same
  // cycle, and then overrun is left as it was.
  always_comb begin
    data_out_d  = data_out_q;
    rdy_d       = rdy_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (commit) begin
      data_out_d  = shift_q;
      rdy_d       = 1'b1;
      frame_err_d = frame_acc_d;
      overrun_d   = overrun_q | (rdy_q & ~rdy_clr);
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_acc_q;
`endif
    end else if (rdy_clr) begin
      rdy_d       = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      stop_idx_q  <= 1'b0;
      // NOTE: the shift register is reset as well, so a frame aborted by
      // reset can never leak partial bits into a later commit.
      shift_q     <= '0;
      frame_acc_q <= 1'b0;
      data_out_q  <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_acc_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      frame_acc_q <= frame_acc_d;
      data_out_q  <= data_out_d;
      rdy_q       <= rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      parity_acc_q <= parity_acc_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rdy       = rdy_q;
  assign data_out  = data_out_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive core: next generation of the team's fixed 8N1 receiver, generalised in data width, oversampling ratio and stop-bit count. Adds an input synchroniser, 3-sample majority voting, false-start rejection, framing and overrun detection, and optional parity. It sits between the pad-side `rx` line and the SoC peripheral register block. It consumes the shared baud-tick generator's oversample enable.

## Interface
- `DATA_BITS`, 8: payload bits per frame, 5..9, LSB first.
- `OVERSAMPLE`, 16: `rx_en` ticks per bit, power of two, 8..64.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `PARITY_ODD`, 0: 0 = even, 1 = odd. Only meaningful with `UART_RX_PARITY_EN`.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `rx` in 1: asynchronous serial input, idle high.
- `rx_en` in 1: oversample tick, one `clk` wide.
- `rdy_clr` in 1: clears `rdy`, `overrun`, `frame_err` and `parity_err`.
- `rdy` out 1: frame available.
- `data_out` out `DATA_BITS`: last received payload.
- `frame_err` out 1: a stop bit of the held frame sampled 0.
- `parity_err` out 1: parity mismatch on the held frame. Tied 0 without the macro.
- `overrun` out 1: a frame completed while `rdy` was already 1. Sticky.
- `busy` out 1: FSM not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, reset value 1, giving `rx_s`. All logic uses `rx_s`.
- **Bit counter** `cnt`: width log2(`OVERSAMPLE`). Increments on `rx_en` only, wraps from `OVERSAMPLE`-1 to 0. Each wrap ends one bit period.
- **Majority vote**: samples are taken at `cnt` = `OVERSAMPLE`/2-1, `OVERSAMPLE`/2 and `OVERSAMPLE`/2+1. The bit value is the 2-of-3 majority, resolved at the tick where `cnt` = `OVERSAMPLE`/2+1.
- **States**: IDLE, START, DATA, PARITY, STOP.
  - **IDLE**: on an `rx_en` tick with `rx_s`=0, go to START with `cnt`=1. That tick counts as `cnt` 0 of the start bit.
  - **START**: when the start-bit vote resolves:
    - vote = 1: false start, return to IDLE, no outputs change;
    - vote = 0: continue; at the `cnt` wrap, go to DATA with `index`=0.
  - **DATA**: the vote is stored into `shift[index]`. At each wrap `index` increments. After `index` = `DATA_BITS`-1 wraps, go to PARITY if the macro is defined, otherwise STOP.
  - **PARITY**: vote the bit, compute the error, go to STOP at the wrap.
  - **STOP**: vote each stop bit. Any stop bit voting 0 sets the frame's framing error. On the vote of the last stop bit, commit and go to IDLE immediately, without waiting for the bit's end, so the FSM can hunt the next start edge.
- **Commit** (one `clk` cycle):
  - `data_out` ← `shift`;
  - `frame_err` and `parity_err` ← the frame's values;
  - `rdy` ← 1;
  - `overrun` ← 1 if `rdy` was already 1. Data is overwritten: newest wins.
- `rdy_clr` in the same cycle as a commit: the commit wins. `rdy`=1, the new flags are loaded, `overrun` is not set.
- A framing error still commits the data.
- **Reset values**: `rdy`, `frame_err`, `parity_err`, `overrun`, `busy`, `data_out`, `cnt`, `index` and `shift` are all 0. FSM is in IDLE.
- `reset` mid-frame aborts the frame and discards partial data.

## Timing
- `rx` to `rx_s` latency: 2 `clk`.
- `rdy` and `data_out` are valid the `clk` after the `rx_en` tick that resolves the last stop-bit vote. That tick falls at `cnt` = `OVERSAMPLE`/2+1 of the final stop bit.
- The next start bit is accepted on the first `rx_en` tick after returning to IDLE.
- **Tolerance**: at least ±(`OVERSAMPLE`/2-2)/`OVERSAMPLE` of a bit of accumulated drift, measured at the last bit.
- Without `rx_en`, the FSM holds state. `rdy_clr` still acts.

## Configuration
- `UART_RX_PARITY_EN`:
  - **Defined**: one parity bit follows the data. Expected parity = XOR(data) XOR `PARITY_ODD`; a mismatch sets `parity_err` at commit. The frame is 1+`DATA_BITS`+1+`STOP_BITS` bits.
  - **Undefined**: the PARITY state and its logic are absent, `parity_err` is tied 0, and the frame is 1+`DATA_BITS`+`STOP_BITS` bits.

## Structure
- **Shared package** `uart_pkg`: the state encoding (IDLE, START, DATA, PARITY, STOP) and the `OVERSAMPLE`/`DATA_BITS` range-check constants, shared with the future transmitter.
- **Sub-module** `uart_rx_sampler`: synchroniser, `cnt`, 3-sample majority. Outputs `rx_s`, `bit_valid` (vote resolved, 1-cycle pulse), `bit_val` and `bit_end` (`cnt` wrap).

## Test plan
- 8N1, `OVERSAMPLE`=16, send 0xA5 → `data_out`=0xA5, `rdy`=1, all error flags 0.
- `rx` low for 4 ticks then high → no commit, `busy` returns to 0 within 9 ticks, `rdy` stays 0.
- Send 0x3C with stop bit = 0 → `data_out`=0x3C, `frame_err`=1. Then `rdy_clr` → `rdy`=0, `frame_err`=0.
- Send 0x11 then 0x22 back-to-back with no `rdy_clr` → `data_out`=0x22, `overrun`=1. Assert `rdy_clr` on the commit cycle of a third frame → `rdy`=1, `overrun` unchanged.
- With `UART_RX_PARITY_EN` and `PARITY_ODD`=0, send 0x3C with parity bit 1 → `parity_err`=1. Send with parity bit 0 → `parity_err`=0.
- `reset` asserted during data bit 3, then a clean 0x5A frame → all outputs 0 after reset, then `data_out`=0x5A with no stale bits.
